// File: rtl/rs_encoder.sv
// Serial RS(7,3) systematic encoder over GF(2^3), primitive polynomial x^3+x+1.
// Accepts a message in IDLE, shifts its three symbols through a 4-stage LFSR, then registers the codeword.
module rs_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  message,
  output logic [20:0] codeword,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [8:0]  msg_q;
  logic [1:0]  cnt;
  logic [2:0]  r3, r2, r1, r0;
  logic [2:0]  sym, fb;

  // Constant multipliers for the generator taps 2 and 3, reduced modulo x^3+x+1.
  function automatic logic [2:0] gf_mul2(input logic [2:0] x);
    return {x[1:0], 1'b0} ^ (x[2] ? 3'b011 : 3'b000);
  endfunction

  function automatic logic [2:0] gf_mul3(input logic [2:0] x);
    return gf_mul2(x) ^ x;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sym = msg_q[2:0];
    case (cnt)
      2'd0:    sym = msg_q[8:6];
      2'd1:    sym = msg_q[5:3];
      default: sym = msg_q[2:0];
    endcase
    fb = sym ^ r3;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SHIFT;
      SHIFT:   if (cnt == 2'd2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q    <= '0;
      cnt      <= '0;
      r3       <= '0;
      r2       <= '0;
      r1       <= '0;
      r0       <= '0;
      codeword <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            msg_q <= message;
            cnt   <= '0;
            r3    <= '0;
            r2    <= '0;
            r1    <= '0;
            r0    <= '0;
          end
        end
        SHIFT: begin
          r3  <= r2 ^ gf_mul3(fb);
          r2  <= r1 ^ fb;
          r1  <= r0 ^ gf_mul2(fb);
          r0  <= gf_mul3(fb);
          cnt <= cnt + 2'd1;
        end
        DONE: begin
          codeword <= {msg_q, r3, r2, r1, r0};
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder: directed scenarios plus a full message sweep
// against a polynomial long-division reference and a syndrome evaluation.
module tb_rs_encoder;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [8:0]  message;
  logic [20:0] codeword;
  logic        valid;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  rs_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .message  (message),
    .codeword (codeword),
    .valid    (valid),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Generic GF(8) multiply: shift-and-add with reduction by x^3+x+1 (0b1011).
  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    int x, y, p;
    x = int'(a); y = int'(b); p = 0;
    for (int i = 0; i < 3; i++) begin
      if ((y & 1) != 0) p = p ^ x;
      y = y >> 1;
      x = x << 1;
      if ((x & 8) != 0) x = x ^ 11;
    end
    return p[2:0];
  endfunction

  // Reference: c(x) = m(x)x^4 + (m(x)x^4 mod g(x)) by long division.
  function automatic logic [20:0] ref_cw(input logic [8:0] m);
    logic [2:0] d [0:6];
    logic [2:0] g [0:4];
    logic [2:0] q;
    g[4] = 3'd1; g[3] = 3'd3; g[2] = 3'd1; g[1] = 3'd2; g[0] = 3'd3;
    for (int i = 0; i < 4; i++) d[i] = 3'd0;
    d[6] = m[8:6]; d[5] = m[5:3]; d[4] = m[2:0];
    for (int i = 6; i >= 4; i--) begin
      q = d[i];
      for (int j = 0; j <= 4; j++) d[i-4+j] = d[i-4+j] ^ gmul(q, g[j]);
    end
    return {m, d[3], d[2], d[1], d[0]};
  endfunction

  // Evaluates the codeword polynomial at a, a^2, a^3, a^4; all zero for a valid codeword.
  function automatic logic [11:0] syndromes(input logic [20:0] cw);
    logic [2:0] roots [0:3];
    logic [2:0] acc;
    logic [11:0] s;
    roots[0] = 3'd2; roots[1] = 3'd4; roots[2] = 3'd3; roots[3] = 3'd6;
    s = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 3'd0;
      for (int k = 6; k >= 0; k--) acc = gmul(acc, roots[r]) ^ cw[3*k +: 3];
      s[3*r +: 3] = acc;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One enable pulse; message is scrambled after acceptance. Returns the observed codeword.
  task automatic encode(input logic [8:0] m, input string tag, output logic [20:0] cw);
    int k;
    @(negedge clk); enable = 1'b1; message = m;
    @(negedge clk); enable = 1'b0; message = 9'($urandom);
    k = 1;
    while (!valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    cw = codeword;
    check({tag, "_latency"}, k, 5);
    check({tag, "_cw"}, codeword, ref_cw(m));
    check({tag, "_syn"}, syndromes(codeword), 0);
    check({tag, "_busy_at_valid"}, busy, 0);
    @(negedge clk);
    check({tag, "_valid_1cyc"}, valid, 0);
  endtask

  initial begin
    logic [20:0] cw;
    int k, t1, t2, pulses;
    logic [20:0] cap;

    reset = 1'b0; enable = 1'b0; message = '0;
    #12;
    check("reset_cw", codeword, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    @(negedge clk); reset = 1'b1;

    encode(9'o001, "m001", cw);
    check("m001_const", cw, 21'o0013123);

    // Idle with enable low: codeword holds, no pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); message = 9'($urandom);
    end
    check("hold_cw", codeword, 21'o0013123);
    check("hold_valid", valid, 0);

    encode(9'o016, "m016", cw);
    check("m016_const", cw, 21'o0165724);
    encode(9'o000, "m000", cw);
    check("m000_const", cw, 21'o0000000);

    // Enable held high: back-to-back encodes 5 cycles apart.
    @(negedge clk); enable = 1'b1; message = 9'o001;
    @(negedge clk); message = 9'o016;
    k = 1;
    while (!valid && k < 12) begin @(negedge clk); k++; end
    t1 = cyc;
    check("b2b_first_cw", codeword, 21'o0013123);
    k = 0;
    do begin @(negedge clk); k++; end while (!valid && k < 12);
    t2 = cyc;
    enable = 1'b0;
    check("b2b_second_cw", codeword, 21'o0165724);
    check("b2b_spacing", t2 - t1, 5);
    @(negedge clk);
    check("b2b_no_third", busy, 0);

    // Message changes and enable re-pulsed while shifting must be ignored.
    @(negedge clk); enable = 1'b1; message = 9'o016;
    @(negedge clk); enable = 1'b1; message = 9'($urandom);
    @(negedge clk); enable = 1'b1; message = 9'($urandom);
    @(negedge clk); enable = 1'b0; message = 9'($urandom);
    pulses = 0; cap = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid) begin pulses++; cap = codeword; end
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_cw", cap, 21'o0165724);

    // Asynchronous reset mid-shift.
    @(negedge clk); enable = 1'b1; message = 9'o777;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_cw", codeword, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("rst_abort_no_valid", pulses, 0);
    check("rst_abort_cw", codeword, 0);
    encode(9'o001, "post_rst", cw);
    check("post_rst_const", cw, 21'o0013123);

    // Random messages, then the full message space.
    for (int i = 0; i < 20; i++) encode(9'($urandom), "rand", cw);
    for (int m = 0; m < 512; m++) encode(9'(m), "sweep", cw);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
